// File: rtl/ddr3_pkg.sv
// Shared DDR3 bring-up definitions: sequencer state encoding and default 100 MHz cycle counts.
// The init FSM reuses the timing constants below for its own mode-register delays.
package ddr3_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_LOCK = 3'd0;
    localparam seq_state_t S_RST  = 3'd1;
    localparam seq_state_t S_CKE  = 3'd2;
    localparam seq_state_t S_XPR  = 3'd3;
    localparam seq_state_t S_DONE = 3'd4;

    // Defaults assume a 100 MHz controller clock.
    localparam int unsigned DEF_LOCK_CYCLES    = 1024;
    localparam int unsigned DEF_RESET_CYCLES   = 20000;
    localparam int unsigned DEF_CKE_CYCLES     = 50000;
    localparam int unsigned DEF_XPR_CYCLES     = 27;
    localparam int unsigned DEF_TMRD_CYCLES    = 4;
    localparam int unsigned DEF_TMOD_CYCLES    = 12;
    localparam int unsigned DEF_TZQINIT_CYCLES = 512;
    localparam int unsigned DEF_CNT_W          = 16;

    localparam int unsigned FAST_SIM_CAP = 16;

    function automatic int unsigned cap_cycles(input int unsigned n, input int unsigned cap);
        return (n > cap) ? cap : n;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ddr3_reset_seq.sv
// DDR3 power-up sequencer: qualifies PLL lock, then times sys_rst_n, RESET#, CKE and tXPR.
// Define DDR3_RESET_SEQ_FAST_SIM_EN to cap every delay at 16 cycles (simulation only).
module ddr3_reset_seq
    import ddr3_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned CKE_CYCLES   = DEF_CKE_CYCLES,
    parameter int unsigned XPR_CYCLES   = DEF_XPR_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic sys_rst_n,
    output logic ddr_reset_n,
    output logic ddr_cke,
    output logic init_done
);

`ifdef DDR3_RESET_SEQ_FAST_SIM_EN
    localparam int unsigned LockEff  = cap_cycles(LOCK_CYCLES, FAST_SIM_CAP);
    localparam int unsigned ResetEff = cap_cycles(RESET_CYCLES, FAST_SIM_CAP);
    localparam int unsigned CkeEff   = cap_cycles(CKE_CYCLES, FAST_SIM_CAP);
    localparam int unsigned XprEff   = cap_cycles(XPR_CYCLES, FAST_SIM_CAP);
`else
    localparam int unsigned LockEff  = LOCK_CYCLES;
    localparam int unsigned ResetEff = RESET_CYCLES;
    localparam int unsigned CkeEff   = CKE_CYCLES;
    localparam int unsigned XprEff   = XPR_CYCLES;
`endif

    // A state of N cycles loads N-1 on entry and leaves on the cycle it reads 0.
    localparam logic [CNT_W-1:0] LockLoad  = CNT_W'(LockEff - 1);
    localparam logic [CNT_W-1:0] ResetLoad = CNT_W'(ResetEff - 1);
    localparam logic [CNT_W-1:0] CkeLoad   = CNT_W'(CkeEff - 1);
    localparam logic [CNT_W-1:0] XprLoad   = CNT_W'(XprEff - 1);

    logic             lock_s;
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       outs_q, outs_d;
    logic             cnt_zero;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOCK;
            cnt_q   <= LockLoad;
            outs_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        if (!lock_s) begin
            // Lock loss wins over any expiry; S_LOCK also just keeps reloading here.
            state_d = S_LOCK;
            cnt_d   = LockLoad;
        end else begin
            unique case (state_q)
                S_LOCK: begin
                    if (cnt_zero) begin
                        state_d = S_RST;
                        cnt_d   = ResetLoad;
                    end
                end
                S_RST: begin
                    if (cnt_zero) begin
                        state_d = S_CKE;
                        cnt_d   = CkeLoad;
                    end
                end
                S_CKE: begin
                    if (cnt_zero) begin
                        state_d = S_XPR;
                        cnt_d   = XprLoad;
                    end
                end
                S_XPR: begin
                    if (cnt_zero) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_LOCK;
                    cnt_d   = LockLoad;
                end
            endcase
        end
    end

    // Decoded from the next state so the registered pins move on the transition edge.
    always_comb begin
        outs_d = 4'b0000;
        unique case (state_d)
            S_LOCK:  outs_d = 4'b0000;
            S_RST:   outs_d = 4'b1000;
            S_CKE:   outs_d = 4'b1100;
            S_XPR:   outs_d = 4'b1110;
            S_DONE:  outs_d = 4'b1111;
            default: outs_d = 4'b0000;
        endcase
    end

    assign sys_rst_n   = outs_q[3];
    assign ddr_reset_n = outs_q[2];
    assign ddr_cke     = outs_q[1];
    assign init_done   = outs_q[0];

endmodule
